mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port of the RISC-V core between the instruction-fetch requester and the load/store data requester. It sequences one memory transaction at a time through a request/grant/response handshake and arbitrates round-robin when both sides request together. It returns the response only to the requester that owns the transaction. The block sits between the fetch/LSU logic driven by the control unit's `mem_wr_en_o`, `regf_rd_src_o` and `alu_op_o` decisions and the external memory, and gives the core its stall condition.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`

Ports:
- `clk_i` input 1 — clock; all state changes on the rising edge
- `rst_ni` input 1 — reset, asynchronous, active-low
- `if_req_i` input 1 — fetch request; held until `if_gnt_o`
- `if_addr_i` input ADDR_W — fetch address
- `if_gnt_o` output 1 — fetch request accepted by memory
- `if_rvalid_o` output 1 — fetch data valid
- `if_rdata_o` output DATA_W — fetch data
- `d_req_i` input 1 — data request; held until `d_gnt_o`
- `d_we_i` input 1 — 1 = store, 0 = load
- `d_be_i` input DATA_W/8 — byte enables
- `d_addr_i` input ADDR_W — data address
- `d_wdata_i` input DATA_W — store data
- `d_gnt_o` output 1 — data request accepted
- `d_rvalid_o` output 1 — load data valid, or store acknowledged
- `d_rdata_o` output DATA_W — load data
- `mem_req_o` output 1 — memory request (registered)
- `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` output — registered transaction attributes
- `mem_gnt_i` input 1 — memory accepts the request
- `mem_rvalid_i` input 1 — memory response valid; one response per accepted request, stores included
- `mem_rdata_i` input DATA_W — memory response data
- `busy_o` output 1 — a transaction is in flight (state is not IDLE)
- `err_o` output 1 — sticky protocol error

## Operation
- The FSM has three states: IDLE, REQ and WAIT. One transaction is outstanding at most.
- **Arbitration:**
  - Sampled in IDLE, and in WAIT on the cycle `mem_rvalid_i` = 1.
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not in `last_owner` wins.
  - `last_owner` updates to the winner at each arbitration.
- **IDLE:**
  - On a winner, latch `owner` and the attributes into the `mem_*` registers, then go to REQ.
  - Fetch transactions drive `mem_we_o` = 0, `mem_be_o` = all ones and `mem_wdata_o` = 0.
- **REQ:**
  - `mem_req_o` = 1 and the attributes are held stable.
  - When `mem_gnt_i` = 1, the owner's `*_gnt_o` = 1 that same cycle (combinational `mem_gnt_i & owner`).
  - On the next edge, go to WAIT with `mem_req_o` = 0.
- **WAIT:**
  - When `mem_rvalid_i` = 1, the owner's `*_rvalid_o` = 1 that same cycle.
  - If a new winner exists, go directly to REQ with the new attributes (back-to-back). Otherwise go to IDLE.
- **Data routing:** `if_rdata_o` and `d_rdata_o` are both wired to `mem_rdata_i`. They are meaningful only while the matching `*_rvalid_o` = 1.
- **Error:** `mem_rvalid_i` = 1 in IDLE or REQ sets `err_o`. It is ignored for routing, and `err_o` clears only on reset.
- **Bad `mem_gnt_i`:** `mem_gnt_i` = 1 outside REQ is ignored and does not set `err_o`.
- **Request withdrawal:** dropping a requester's `*_req_i` before grant is illegal. The latched transaction still completes, and the response is still routed to the owner.

## Timing
- **Reset values:**
  - State = IDLE and `last_owner` = data, so the first tie goes to fetch.
  - `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wdata_o` = 0.
  - All `*_gnt_o`, `*_rvalid_o`, `busy_o` and `err_o` = 0.
- **Reset mid-transaction:** forces IDLE immediately, drops `mem_req_o`, and abandons any outstanding response. A late `mem_rvalid_i` after reset sets `err_o`.
- **Latency:**
  - Request in IDLE at cycle N gives `mem_req_o` = 1 at N+1.
  - Minimum turnaround is grant at N+1 and `rvalid` at N+2: three cycles from request to data.
  - Back-to-back transactions lose no cycle: the next `mem_req_o` rises on the edge after the `rvalid` cycle.
- **Stretching:** `mem_gnt_i` and `mem_rvalid_i` may each be delayed by any number of cycles. All attributes stay constant throughout REQ.
- **`busy_o`:** 1 from the cycle after an IDLE arbitration until the edge after the final `rvalid`.

## Test plan
- **Single fetch:** reset, then `if_req_i` = 1 with `if_addr_i` = 0x0000_0040; memory grants immediately and responds next cycle with 0x0051_3093 → `mem_req_o` = 1 for 1 cycle, `if_gnt_o` pulses once, `if_rvalid_o` = 1 with `if_rdata_o` = 0x0051_3093, `d_*` outputs stay 0.
- **Tie then round-robin:**
  - Setup: `if_req_i` and `d_req_i` both held from reset with a load at 0x1000.
  - Required: fetch is served first (because `last_owner` = data), then the data request follows back-to-back with no IDLE cycle.
  - Repeat the tie: fetch is served first again, because the data side was last.
- **Store with wait states:**
  - Setup: `d_we_i` = 1, `d_be_i` = 0x3, `d_addr_i` = 0x2004, `d_wdata_i` = 0xDEAD_BEEF; `mem_gnt_i` is delayed 3 cycles and `mem_rvalid_i` 2 more.
  - Required: the `mem_*` attributes are stable for all 4 REQ cycles, `d_gnt_o` is 1 only in the grant cycle, and `d_rvalid_o` = 1 exactly once.
- **Protocol error:** `mem_rvalid_i` = 1 while IDLE → `err_o` = 1 from the next cycle and stays 1 through later good transactions until `rst_ni` = 0.
- **Reset mid-operation:**
  - Setup: assert `rst_ni` = 0 while in WAIT of a data load.
  - Required: `mem_req_o`, `busy_o` and `d_rvalid_o` are 0 immediately.
  - A stale `mem_rvalid_i` after reset release is not routed to either requester and sets `err_o`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the unified memory port.
// The arbiter takes the slave view. The environment (requesters plus memory) takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_W-1:0]     if_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [DATA_W/8-1:0]   d_be_i;
    logic [ADDR_W-1:0]     d_addr_i;
    logic [DATA_W-1:0]     d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_W-1:0]     d_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    logic                  busy_o;
    logic                  err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output busy_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch and load/store.
// It allows one outstanding transaction and routes each response back to the owning requester.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {FETCH, DATA} side_t;

    state_t            state;
    state_t            state_next;
    side_t             owner;
    side_t             last_owner;
    side_t             winner;
    logic              win_valid;
    logic              arb_en;
    logic              launch;
    logic              grant;
    logic              resp;
    logic              bad_rvalid;
    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // On a tie, the side that did not win last time takes the port.
    always_comb begin
        win_valid = bus.if_req_i | bus.d_req_i;
        winner    = FETCH;
        if (bus.d_req_i && (!bus.if_req_i || last_owner == FETCH))
            winner = DATA;
    end

    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (win_valid)
                    state_next = REQ;
            end
            REQ: begin
                if (bus.mem_gnt_i)
                    state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    arb_en     = 1'b1;
                    state_next = win_valid ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign launch     = arb_en & win_valid;
    assign grant      = (state == REQ) & bus.mem_gnt_i;
    assign resp       = (state == WAIT) & bus.mem_rvalid_i;
    assign bad_rvalid = bus.mem_rvalid_i & (state != WAIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_owner <= DATA;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next == REQ);
            if (bad_rvalid)
                err <= 1'b1;
            // Attributes are latched only at arbitration, so they hold steady throughout REQ.
            if (launch) begin
                owner      <= winner;
                last_owner <= winner;
                if (winner == DATA) begin
                    mem_we    <= bus.d_we_i;
                    mem_be    <= bus.d_be_i;
                    mem_addr  <= bus.d_addr_i;
                    mem_wdata <= bus.d_wdata_i;
                end else begin
                    mem_we    <= 1'b0;
                    mem_be    <= '1;
                    mem_addr  <= bus.if_addr_i;
                    mem_wdata <= '0;
                end
            end
        end
    end

    assign bus.if_gnt_o    = grant & (owner == FETCH);
    assign bus.d_gnt_o     = grant & (owner == DATA);
    assign bus.if_rvalid_o = resp & (owner == FETCH);
    assign bus.d_rvalid_o  = resp & (owner == DATA);
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.d_rdata_o   = bus.mem_rdata_i;

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.busy_o      = (state != IDLE);
    assign bus.err_o       = err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   rv_cnt;
    int   gnt_cnt;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  e_hs;    // {if_gnt, if_rvalid, d_gnt, d_rvalid}
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [1:0]  e_st;    // {busy, err}
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.d_req_i      = 1'b0;
        bus.d_we_i       = 1'b0;
        bus.d_be_i       = '0;
        bus.d_addr_i     = '0;
        bus.d_wdata_i    = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();

        // single fetch
        tbl.push_back('{1'b1,1'b1,32'h40,1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,      4'b0000,1'b0,1'b0,4'h0,32'h0,   2'b00});
        tbl.push_back('{1'b1,1'b1,32'h40,1'b0,1'b0,4'h0,32'h0,   1'b1,1'b0,32'h0,      4'b1000,1'b1,1'b0,4'hF,32'h40,  2'b10});
        tbl.push_back('{1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,   1'b0,1'b1,32'h00513093,4'b0100,1'b0,1'b0,4'hF,32'h40, 2'b10});
        tbl.push_back('{1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,      4'b0000,1'b0,1'b0,4'hF,32'h40,  2'b00});
        // tie from reset, round-robin, back-to-back
        tbl.push_back('{1'b0,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b0,1'b0,32'h0,      4'b0000,1'b0,1'b0,4'h0,32'h0,   2'b00});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b0,1'b0,32'h0,      4'b0000,1'b0,1'b0,4'h0,32'h0,   2'b00});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b1,1'b0,32'h0,      4'b1000,1'b1,1'b0,4'hF,32'h80,  2'b10});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b0,1'b1,32'h11111111,4'b0100,1'b0,1'b0,4'hF,32'h80, 2'b10});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b1,1'b0,32'h0,      4'b0010,1'b1,1'b0,4'hF,32'h1000,2'b10});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b0,1'b1,32'h22222222,4'b0001,1'b0,1'b0,4'hF,32'h1000,2'b10});
        tbl.push_back('{1'b1,1'b1,32'h80,1'b1,1'b0,4'hF,32'h1000,1'b1,1'b0,32'h0,      4'b1000,1'b1,1'b0,4'hF,32'h80,  2'b10});
        tbl.push_back('{1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,   1'b0,1'b1,32'h33333333,4'b0100,1'b0,1'b0,4'hF,32'h80, 2'b10});
        tbl.push_back('{1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,      4'b0000,1'b0,1'b0,4'hF,32'h80,  2'b00});

        repeat (3) cyc();
        @(negedge clk);
        check("reset_state",
              {bus.if_gnt_o, bus.if_rvalid_o, bus.d_gnt_o, bus.d_rvalid_o, bus.mem_req_o, bus.mem_we_o,
               bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o, bus.err_o}, 64'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc();
            rst_n            = tbl[k].rst_n;
            bus.if_req_i     = tbl[k].if_req;
            bus.if_addr_i    = tbl[k].if_addr;
            bus.d_req_i      = tbl[k].d_req;
            bus.d_we_i       = tbl[k].d_we;
            bus.d_be_i       = tbl[k].d_be;
            bus.d_addr_i     = tbl[k].d_addr;
            bus.d_wdata_i    = '0;
            bus.mem_gnt_i    = tbl[k].gnt;
            bus.mem_rvalid_i = tbl[k].rvalid;
            bus.mem_rdata_i  = tbl[k].rdata;
            @(negedge clk);
            check($sformatf("vec%0d_outputs", k),
                  {bus.if_gnt_o, bus.if_rvalid_o, bus.d_gnt_o, bus.d_rvalid_o, bus.mem_req_o, bus.mem_we_o,
                   bus.mem_be_o, bus.mem_addr_o, bus.busy_o, bus.err_o},
                  {tbl[k].e_hs, tbl[k].e_req, tbl[k].e_we, tbl[k].e_be, tbl[k].e_addr, tbl[k].e_st});
            if (tbl[k].e_hs[2])
                check($sformatf("vec%0d_if_rdata", k), bus.if_rdata_o, tbl[k].rdata);
            if (tbl[k].e_hs[0])
                check($sformatf("vec%0d_d_rdata", k), bus.d_rdata_o, tbl[k].rdata);
        end

        // store with 3 grant wait states and 2 response wait states
        cyc();
        idle_inputs();
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_be_i    = 4'h3;
        bus.d_addr_i  = 32'h2004;
        bus.d_wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        check("store_idle_busy", bus.busy_o, 1'b0);
        gnt_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.mem_gnt_i = (i == 3);
            @(negedge clk);
            check($sformatf("store_req%0d_attr", i),
                  {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
                  {1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF});
            check($sformatf("store_req%0d_gnt", i), {bus.d_gnt_o, bus.if_gnt_o}, {(i == 3), 1'b0});
            if (bus.d_gnt_o) gnt_cnt++;
        end
        check("store_gnt_count", gnt_cnt, 1);
        rv_cnt = 0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            bus.d_req_i      = 1'b0;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = (j == 2);
            @(negedge clk);
            check($sformatf("store_wait%0d", j),
                  {bus.mem_req_o, bus.busy_o, bus.d_rvalid_o, bus.if_rvalid_o}, {1'b0, 1'b1, (j == 2), 1'b0});
            if (bus.d_rvalid_o) rv_cnt++;
        end
        cyc();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("store_done_busy", {bus.busy_o, bus.mem_req_o}, 2'b00);
        check("store_rvalid_count", rv_cnt, 1);

        // stray response while idle
        cyc();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk);
        check("err_stray_route", {bus.if_rvalid_o, bus.d_rvalid_o, bus.err_o}, 3'b000);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("err_set", bus.err_o, 1'b1);
        cyc();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h44;
        cyc();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("err_fetch_gnt", {bus.if_gnt_o, bus.mem_addr_o}, {1'b1, 32'h44});
        cyc();
        bus.if_req_i     = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h12345678;
        @(negedge clk);
        check("err_fetch_resp", {bus.if_rvalid_o, bus.if_rdata_o}, {1'b1, 32'h12345678});
        cyc();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("err_sticky", {bus.err_o, bus.busy_o}, 2'b10);
        cyc();
        rst_n = 1'b0;
        #1;
        check("err_clear_on_reset", bus.err_o, 1'b0);
        cyc();
        rst_n = 1'b1;

        // reset during WAIT of a load, then a stale response
        cyc();
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_be_i   = 4'hF;
        bus.d_addr_i = 32'h3000;
        cyc();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("rst_load_gnt", {bus.d_gnt_o, bus.mem_req_o, bus.mem_addr_o}, {1'b1, 1'b1, 32'h3000});
        cyc();
        bus.d_req_i   = 1'b0;
        bus.mem_gnt_i = 1'b0;
        @(negedge clk);
        check("rst_load_wait", {bus.busy_o, bus.mem_req_o}, 2'b10);
        cyc();
        rst_n            = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        check("rst_mid_immediate", {bus.mem_req_o, bus.busy_o, bus.d_rvalid_o, bus.if_rvalid_o}, 4'b0000);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        cyc();
        rst_n            = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        check("rst_stale_route", {bus.d_rvalid_o, bus.if_rvalid_o, bus.err_o}, 3'b000);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rst_stale_err", {bus.err_o, bus.busy_o}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
